// File: rtl/reverb_config_loader.sv
// Byte-stream loader for the reverberator tau/gain tables: frames land in shadow registers and a commit frame copies them live.
// Optional feature macro REVERB_CFG_CHECKSUM_EN appends an XOR checksum byte to every frame.
module reverb_config_loader #(
   parameter int WIDTH                  = 24,
   parameter int FIXED_POINT            = 8,
   parameter int MAX_FILTER_FIFO_LENGTH = 4096,
   parameter int MAXDELAY               = MAX_FILTER_FIFO_LENGTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [7:0]                   in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [WIDTH+FIXED_POINT-1:0] tau  [6],
   output logic [WIDTH+FIXED_POINT-1:0] gain [7],
   output logic                         write,
   output logic                         err
);

   localparam int          WORD     = WIDTH + FIXED_POINT;
   localparam logic [31:0] TAU_MAX  = 32'(MAXDELAY);
   localparam logic [31:0] GAIN_MAX = 32'(1) << FIXED_POINT;
   localparam logic [7:0]  HEADER   = 8'hA5;
   localparam logic [7:0]  COMMIT   = 8'hFF;

   typedef enum logic [2:0] {
      HDR,
      IDX,
      DATA,
`ifdef REVERB_CFG_CHECKSUM_EN
      CHK,
`endif
      APPLY
   } state_t;

   state_t            state;
   state_t            next_state;
   logic [1:0]        byte_cnt;
   logic [7:0]        index;
`ifdef REVERB_CFG_CHECKSUM_EN
   logic [31:0]       assembly;
   logic [7:0]        csum;
`else
   logic [23:0]       assembly;
`endif
   logic [31:0]       word_next;
   logic              accept;
   logic              idx_ok;
   logic [2:0]        gain_sel;
   logic              frame_done;
   logic              store_en;
   logic              store_bad;
   logic [31:0]       store_word;
   logic [WORD-1:0]   shadow_tau  [6];
   logic [WORD-1:0]   shadow_gain [7];

   assign accept    = in_valid && in_ready;
   assign idx_ok    = (in_data <= 8'd12) || (in_data == COMMIT);
   assign word_next = {assembly[23:0], in_data};
   assign gain_sel  = 3'(index[3:0] - 4'd6);

   // A frame is complete once its last byte is accepted; with the checksum the last byte must also match.
   always_comb begin
      frame_done = 1'b0;
      store_word = word_next;
`ifdef REVERB_CFG_CHECKSUM_EN
      store_word = assembly;
      frame_done = accept && (state == CHK) && (in_data == csum);
`else
      frame_done = accept && (state == DATA) && (byte_cnt == 2'd3);
`endif
      store_en  = frame_done && (index != COMMIT);
      store_bad = (index < 8'd6) ? (store_word > TAU_MAX) : (store_word > GAIN_MAX);
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= HDR;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      unique case (state)
         HDR:     if (accept && in_data == HEADER) next_state = IDX;
         IDX:     if (accept) next_state = idx_ok ? DATA : HDR;
         DATA:    if (accept && byte_cnt == 2'd3)
`ifdef REVERB_CFG_CHECKSUM_EN
                     next_state = CHK;
         CHK:     if (accept) next_state = (frame_done && index == COMMIT) ? APPLY : HDR;
`else
                     next_state = (index == COMMIT) ? APPLY : HDR;
`endif
         APPLY:   next_state = HDR;
         default: next_state = HDR;
      endcase
   end

   // Output logic: the host link is only stalled while the shadow tables are being copied live
   always_comb begin
      in_ready = (state != APPLY);
   end

   // Frame assembly, shadow tables and the live tables they feed
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_cnt <= '0;
         index    <= '0;
         assembly <= '0;
`ifdef REVERB_CFG_CHECKSUM_EN
         csum     <= '0;
`endif
         write    <= 1'b0;
         err      <= 1'b0;
         for (int i = 0; i < 6; i++) begin
            shadow_tau[i] <= '0;
            tau[i]        <= '0;
         end
         for (int i = 0; i < 7; i++) begin
            shadow_gain[i] <= '0;
            gain[i]        <= '0;
         end
      end else begin
         write <= (state == APPLY);
         if (state == APPLY) begin
            tau  <= shadow_tau;
            gain <= shadow_gain;
            err  <= 1'b0;
         end
         if (accept && state == IDX) begin
            index    <= in_data;
            byte_cnt <= '0;
`ifdef REVERB_CFG_CHECKSUM_EN
            csum     <= in_data;
`endif
            if (!idx_ok) err <= 1'b1;
         end
         if (accept && state == DATA) begin
            assembly <= word_next[$bits(assembly)-1:0];
            byte_cnt <= byte_cnt + 2'd1;
`ifdef REVERB_CFG_CHECKSUM_EN
            csum     <= csum ^ in_data;
`endif
         end
`ifdef REVERB_CFG_CHECKSUM_EN
         if (accept && state == CHK && !frame_done) err <= 1'b1;
`endif
         // Out-of-range values flag an error and leave the shadow entry untouched
         if (store_en) begin
            if (store_bad) begin
               err <= 1'b1;
            end else if (index < 8'd6) begin
               shadow_tau[index[2:0]] <= WORD'(store_word);
            end else begin
               shadow_gain[gain_sel] <= WORD'(store_word);
            end
         end
      end
   end

endmodule

// File: tb/tb_reverb_config_loader.sv
// Scoreboard bench for reverb_config_loader: frame-level model, expected live tables queued per commit and checked on each write pulse.
// Builds with or without REVERB_CFG_CHECKSUM_EN.
module tb_reverb_config_loader;

   localparam int          MAXDELAY = 1000;
   localparam logic [31:0] GAIN_ONE = 32'd256;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] tau  [6];
   logic [31:0] gain [7];
   logic        write;
   logic        err;

   typedef struct packed {
      logic [5:0][31:0] tau;
      logic [6:0][31:0] gain;
      logic [31:0]      cycle;
   } expect_t;

   expect_t     expQ [$];
   logic [31:0] modelShadowTau  [6];
   logic [31:0] modelShadowGain [7];
   logic [31:0] modelLiveTau    [6];
   logic [31:0] modelLiveGain   [7];
   logic        modelErr;
   int          checks = 0;
   int          errors = 0;
   int          cycleCount = 0;
   int          lastAcceptCycle = 0;
   int          readyLow = 0;
   int          expectedReadyLow = 0;

   reverb_config_loader #(
      .WIDTH(24),
      .FIXED_POINT(8),
      .MAXDELAY(MAXDELAY)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .tau(tau),
      .gain(gain),
      .write(write),
      .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCount++;

   // Counts stalled cycles; each applied commit should cost exactly one
   always @(negedge clk) begin
      if (!rst && !in_ready) readyLow++;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // Monitor: every write pulse must match the oldest queued commit
   always @(negedge clk) begin
      expect_t e;
      if (!rst && write) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected write pulse", 32'(write), 32'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("write latency cycle", cycleCount, e.cycle);
            for (int i = 0; i < 6; i++)
               checkOutput($sformatf("commit tau[%0d]", i), tau[i], e.tau[i]);
            for (int i = 0; i < 7; i++)
               checkOutput($sformatf("commit gain[%0d]", i), gain[i], e.gain[i]);
            checkOutput("commit err cleared", 32'(err), 32'd0);
         end
      end
   end

   task automatic resetModel();
      for (int i = 0; i < 6; i++) begin
         modelShadowTau[i] = '0;
         modelLiveTau[i]   = '0;
      end
      for (int i = 0; i < 7; i++) begin
         modelShadowGain[i] = '0;
         modelLiveGain[i]   = '0;
      end
      modelErr = 1'b0;
   endtask

   task automatic checkLive(input string tag);
      for (int i = 0; i < 6; i++)
         checkOutput($sformatf("%s tau[%0d]", tag, i), tau[i], modelLiveTau[i]);
      for (int i = 0; i < 7; i++)
         checkOutput($sformatf("%s gain[%0d]", tag, i), gain[i], modelLiveGain[i]);
      checkOutput({tag, " err"}, 32'(err), 32'(modelErr));
   endtask

   // Holds in_valid high between calls so consecutive bytes go out back to back
   task automatic sendByte(input logic [7:0] b);
      int waits = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && waits < 8) begin
         @(negedge clk);
         waits++;
      end
      if (!in_ready) checkOutput("in_ready wait timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      lastAcceptCycle = cycleCount;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic sendFrameBytes(input logic [7:0] idx, input logic [31:0] value, input bit csumBad);
      logic [7:0] csum;
      csum = idx ^ value[31:24] ^ value[23:16] ^ value[15:8] ^ value[7:0];
      sendByte(8'hA5);
      sendByte(idx);
      sendByte(value[31:24]);
      sendByte(value[23:16]);
      sendByte(value[15:8]);
      sendByte(value[7:0]);
`ifdef REVERB_CFG_CHECKSUM_EN
      sendByte(csumBad ? ~csum : csum);
`endif
   endtask

   // Sends one frame and advances the model; commits queue the expected live tables
   task automatic applyStimulus(input logic [7:0] idx, input logic [31:0] value, input bit csumBad);
      expect_t e;
      sendFrameBytes(idx, value, csumBad);
`ifdef REVERB_CFG_CHECKSUM_EN
      if (csumBad) begin
         modelErr = 1'b1;
         checkOutput("err after bad checksum", 32'(err), 32'd1);
         return;
      end
`endif
      if (idx == 8'hFF) begin
         modelLiveTau  = modelShadowTau;
         modelLiveGain = modelShadowGain;
         modelErr      = 1'b0;
         for (int i = 0; i < 6; i++) e.tau[i] = modelLiveTau[i];
         for (int i = 0; i < 7; i++) e.gain[i] = modelLiveGain[i];
         e.cycle = 32'(lastAcceptCycle + 1);
         expQ.push_back(e);
         expectedReadyLow++;
      end else begin
         if (idx < 8'd6) begin
            if (value > MAXDELAY) modelErr = 1'b1;
            else modelShadowTau[idx] = value;
         end else begin
            if (value > GAIN_ONE) modelErr = 1'b1;
            else modelShadowGain[idx - 8'd6] = value;
         end
         checkOutput($sformatf("err after frame idx %0d value %h", idx, value), 32'(err), 32'(modelErr));
      end
   endtask

   task automatic sendBadIndex(input logic [7:0] idx);
      sendByte(8'hA5);
      sendByte(idx);
      modelErr = 1'b1;
      checkOutput($sformatf("err after bad index %h", idx), 32'(err), 32'd1);
   endtask

   task automatic sendJunk(input int n);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = 8'($urandom_range(0, 255));
         if (b == 8'hA5) b = 8'h5A;
         sendByte(b);
      end
   endtask

   task automatic pulseReset();
      #1 rst = 1'b1;
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      resetModel();
   endtask

   function automatic logic [31:0] randTau();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return 32'(MAXDELAY);
         2:       return 32'(MAXDELAY + 1);
         3:       return $urandom;
         default: return 32'($urandom_range(0, MAXDELAY));
      endcase
   endfunction

   function automatic logic [31:0] randGain();
      case ($urandom_range(0, 7))
         0:       return 32'd0;
         1:       return GAIN_ONE;
         2:       return GAIN_ONE + 32'd1;
         3:       return $urandom;
         default: return 32'($urandom_range(0, 256));
      endcase
   endfunction

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] idx;
      int         r;
      bit         bad;

      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      resetModel();
      repeat (3) @(negedge clk);
      checkOutput("reset in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset write", 32'(write), 32'd0);
      checkLive("reset");
      rst = 1'b0;
      @(negedge clk);

      $display("[TB] directed: gain[0] = 0xB3 then commit");
      applyStimulus(8'h06, 32'h000000B3, 1'b0);
      applyStimulus(8'hFF, 32'h00000000, 1'b0);
      idle(3);
      checkOutput("directed gain[0]", gain[0], 32'h000000B3);
      checkLive("after first commit");

      $display("[TB] directed: gain above unity rejected");
      applyStimulus(8'h07, 32'h00000101, 1'b0);
      applyStimulus(8'hFF, 32'h00000000, 1'b0);
      idle(3);
      checkOutput("directed gain[1] unchanged", gain[1], 32'h0);
      checkLive("after rejected gain");

      $display("[TB] directed: junk bytes before a frame");
      sendByte(8'h3C);
      sendByte(8'h12);
      applyStimulus(8'h05, 32'h00000200, 1'b0);
      applyStimulus(8'hFF, 32'h00000000, 1'b0);
      idle(3);
      checkOutput("directed tau[5]", tau[5], 32'h00000200);

      $display("[TB] directed: illegal index then a good frame");
      sendBadIndex(8'h0D);
      applyStimulus(8'h02, 32'h000001F4, 1'b0);
      applyStimulus(8'hFF, 32'h00000000, 1'b0);
      idle(3);
      checkOutput("directed tau[2]", tau[2], 32'h000001F4);
      checkLive("after bad index recovery");

      $display("[TB] directed: range boundaries and last write wins");
      applyStimulus(8'h01, 32'(MAXDELAY), 1'b0);
      applyStimulus(8'h03, 32'(MAXDELAY + 1), 1'b0);
      applyStimulus(8'h08, GAIN_ONE, 1'b0);
      applyStimulus(8'h09, GAIN_ONE + 32'd1, 1'b0);
      applyStimulus(8'h04, 32'h00000011, 1'b0);
      applyStimulus(8'h04, 32'h00000022, 1'b0);
      applyStimulus(8'hFF, 32'h00000000, 1'b0);
      idle(3);
      checkLive("after boundary commit");

`ifdef REVERB_CFG_CHECKSUM_EN
      $display("[TB] directed: checksum accepted and rejected");
      applyStimulus(8'h06, 32'h000000B3, 1'b0);
      applyStimulus(8'hFF, 32'h00000000, 1'b0);
      applyStimulus(8'h06, 32'h00000011, 1'b1);
      applyStimulus(8'hFF, 32'h00000000, 1'b1);
      applyStimulus(8'hFF, 32'h00000000, 1'b0);
      idle(3);
      checkOutput("checksum gain[0]", gain[0], 32'h000000B3);
`endif

      $display("[TB] directed: frame without commit then reset");
      sendFrameBytes(8'h00, 32'h00000010, 1'b0);
      idle(1);
      pulseReset();
      idle(2);
      checkLive("after reset without commit");
      applyStimulus(8'hFF, 32'h00000000, 1'b0);
      idle(3);
      checkOutput("shadow cleared tau[0]", tau[0], 32'h0);

      $display("[TB] directed: reset during apply");
      applyStimulus(8'h00, 32'h00000055, 1'b0);
      sendFrameBytes(8'hFF, 32'h00000000, 1'b0);
      expectedReadyLow++;
      pulseReset();
      idle(3);
      checkLive("after reset during apply");

      $display("[TB] random frames");
      for (int n = 0; n < 250; n++) begin
         r = $urandom_range(0, 19);
         if (r == 0) begin
            sendJunk($urandom_range(1, 3));
         end else if (r == 1) begin
            sendBadIndex(8'($urandom_range(13, 254)));
         end else begin
            r   = $urandom_range(0, 13);
            idx = (r == 13) ? 8'hFF : 8'(r);
`ifdef REVERB_CFG_CHECKSUM_EN
            bad = ($urandom_range(0, 9) == 0);
`else
            bad = 1'b0;
`endif
            if (idx == 8'hFF) applyStimulus(idx, $urandom, bad);
            else if (idx < 8'd6) applyStimulus(idx, randTau(), bad);
            else applyStimulus(idx, randGain(), bad);
            if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
         end
      end
      applyStimulus(8'hFF, 32'h00000000, 1'b0);
      idle(5);

      checkOutput("expected commits drained", 32'(expQ.size()), 32'd0);
      checkOutput("in_ready low cycles", 32'(readyLow), 32'(expectedReadyLow));
      checkLive("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/reverb_config_loader.md
REVERB_CONFIG_LOADER -- requirements
Module: reverb_config_loader

Interface
REQ-001 Parameter WIDTH, default 24: integer part width; output word is WIDTH+FIXED_POINT bits (32 at defaults).
REQ-002 Parameter MAXDELAY, default MAX_FILTER_FIFO_LENGTH: largest legal tau value.
REQ-003 clk  input  1  system clock; one clock, all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  8  configuration byte from the host link.
REQ-006 in_valid  input  1  in_data valid this cycle.
REQ-007 in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid and in_ready are both high.
REQ-008 tau  output  WORD x 6  live tau array for the reverberator (4 comb, 2 all-pass).
REQ-009 gain  output  WORD x 7  live gain array (index 6 = output mix gain).
REQ-010 write  output  1  one-cycle pulse on the cycle after tau/gain change.
REQ-011 err  output  1  sticky error flag.

Function
REQ-012 Frame format: header 0xA5, index byte, 4 payload bytes MSB first; index 0-5 = tau[i], 6-12 = gain[i-6], 0xFF = commit (payload ignored but still consumed).
REQ-013 States: HDR, IDX, DATA (byte counter 0-3), CHK (only with macro), APPLY; reset state HDR.
REQ-014 HDR: a byte other than 0xA5 is discarded and no error is raised; 0xA5 -> IDX.
REQ-015 IDX: index 0-12 or 0xFF -> DATA; any other value sets err -> HDR.
REQ-016 DATA: shift bytes into a 32-bit assembly register; after the 4th byte, go to CHK or, without the macro, do the validation below.
REQ-017 Validation: a tau outside 0..MAXDELAY, or a gain outside 0..(1<<FIXED_POINT), sets err and leaves the shadow register unchanged; otherwise the shadow register is written. Either way -> HDR.
REQ-018 Commit frame -> APPLY; in APPLY all 13 shadow registers copy to tau/gain in the same edge, write pulses high for exactly the next cycle, err clears, -> HDR.
REQ-019 Outputs never change except on an APPLY edge or reset; a partial frame never affects outputs.
REQ-020 in_ready is high in all states except APPLY; it is low for exactly one cycle per commit.
REQ-021 Back-to-back frames with in_valid held high for consecutive cycles are accepted with no gaps except the APPLY cycle.
REQ-022 A second write to the same shadow index before a commit overwrites it; the last write wins.
REQ-023 Latency: the commit frame's final byte is accepted on edge N, outputs update on edge N+1, and write is high during cycle N+1 to N+2.

Reset
REQ-024 On rst, asynchronously: state = HDR, byte counter = 0, in_ready = 1, write = 0, err = 0.
REQ-025 On rst, shadow and live tau are zeroed and shadow and live gain are zeroed, so the reverberator is bypassed.
REQ-026 rst mid-frame or during APPLY discards the frame; no write pulse is produced after rst deasserts.

Configuration
REQ-027 Macro REVERB_CFG_CHECKSUM_EN: when defined, the frame gains a 7th byte equal to the XOR of the index and the 4 payload bytes, checked in CHK.
REQ-028 With the macro, a checksum mismatch sets err and drops the frame, including a commit frame; without the macro, CHK does not exist and frames are 6 bytes.

Verification
REQ-029 Send A5 06 00 00 00 B3, then A5 FF 00 00 00 00 -> gain[0] = 0x000000B3 (0.699), write high for one cycle, err = 0.
REQ-030 Send A5 07 00 00 01 01 (gain 1.004), then commit -> err = 1, gain[1] unchanged (0), write pulses, then err clears on that commit.
REQ-031 Send A5 00 00 00 00 10 (no commit), then assert rst -> tau[0] stays 0, write never pulses.
REQ-032 Send bytes 3C 12 A5 05 00 00 02 00, then commit -> junk bytes ignored, tau[5] = 0x200, err = 0.
REQ-033 Send index 0x0D frame -> err = 1, state returns to HDR; the next valid frame plus commit is applied.
REQ-034 With REVERB_CFG_CHECKSUM_EN defined: A5 06 00 00 00 B3 B5 accepted; the same frame with checksum 00 -> err = 1 and gain[0] unchanged.
